clock_oscillator: RTL and testbench
===================================

// Module: clock_oscillator
// PURPOSE
//   Synthesizable clock oscillator/divider producing the system clock that drives the
//   fetch stage and instruction memory (clk_out feeds instr_mem.clk).
//   Derives a 50%-duty square wave from the reference clock with a runtime-loadable
//   half-period. Also provides single-cycle edge strobes and a free-running count of
//   generated cycles, used by benches to step pc once per `CYCLE.
// PARAMETERS
//   DIV_WIDTH     16  width of half-period value, in reference clk cycles
//   DEFAULT_HALF  1   half-period in effect after reset (0 treated as 1)
//   CNT_WIDTH     32  width of generated-cycle counter
// PORTS
//   clk          in   1          reference clock; all logic on rising edge
//   rst_n        in   1          asynchronous, active-low reset
//   enable       in   1          1 = oscillate; 0 = freeze all state
//   half_period  in   DIV_WIDTH  requested half-period (ref cycles); 0 treated as 1
//   load         in   1          sample half_period into pending register this cycle
//   clk_out      out  1          generated clock, 50% duty, period 2*active_half
//   rise_pulse   out  1          1-cycle strobe, high in the cycle clk_out becomes 1
//   fall_pulse   out  1          1-cycle strobe, high in the cycle clk_out becomes 0
//   cycle_count  out  CNT_WIDTH  number of clk_out rising edges since reset
// BEHAVIOUR
//   Reset (rst_n=0, async, immediate): clk_out=0, rise_pulse=0, fall_pulse=0,
//     cycle_count=0, phase counter=0, active_half=max(DEFAULT_HALF,1),
//     pending_half=active_half, pending_valid=0. Release is synchronous to clk.
//   Every output is a direct register; no combinational path from any input to outputs.
//   Phase counter counts 0..active_half-1 while enable=1. In the cycle it equals
//     active_half-1: counter->0, clk_out toggles, and matching strobe asserts with the
//     new clk_out level. Otherwise counter increments and both strobes are 0.
//   First edge after reset: clk_out rises active_half cycles after the first enabled
//     clk edge; rise_pulse=1 in that same cycle; cycle_count becomes 1.
//   cycle_count increments by 1 on each 0->1 toggle; wraps modulo 2^CNT_WIDTH.
//   load=1: pending_half<=(half_period==0 ? 1 : half_period), pending_valid<=1.
//     Load while pending_valid=1 overwrites (last load wins).
//   Pending value becomes active_half only at a toggle boundary (the cycle in which
//     clk_out toggles); pending_valid clears then. A mid-phase load never shortens or
//     stretches the current half-period.
//   load coincident with toggle: toggle uses old active_half; new value is pending,
//     applied at the next toggle boundary.
//   enable=0: counter, clk_out, cycle_count and pending state hold; strobes forced 0;
//     load still accepted. Resuming continues the partial phase where it stopped.
//   active_half=1: clk_out toggles every ref cycle (period 2 ref cycles); strobes
//     alternate rise/fall each cycle.
//   rise_pulse and fall_pulse are never high together.
//   Reset mid-phase: all state returns to reset values; any pending load is discarded.
// TESTING
//   1 reset, enable=1, DEFAULT_HALF=1 -> clk_out 0,1,0,1 per ref cycle; cycle_count
//     1,1,2,2,...; rise_pulse on every other cycle.
//   2 load half_period=4 while clk_out=0 -> current phase finishes at old length;
//     then 4 high / 4 low cycles; rise/fall strobes each exactly 1 cycle.
//   3 load half_period=0 -> treated as 1; clk_out toggles every cycle after boundary.
//   4 half=3, drop enable for 5 cycles mid-phase -> clk_out/counter frozen, strobes 0;
//     on resume remaining phase cycles complete, total high time 3 enabled cycles.
//   5 assert rst_n=0 asynchronously mid-high-phase -> clk_out and cycle_count 0
//     immediately, before next clk edge; pending load discarded.
//   6 CNT_WIDTH=4, run 17 rising edges -> cycle_count wraps to 1.

Source files
------------

// File: rtl/clock_oscillator.sv
// Programmable clock divider: 50%-duty clk_out with a runtime-loadable half-period,
// registered edge strobes and a count of generated rising edges.
module clock_oscillator #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DEFAULT_HALF = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic                 load,
  output logic                 clk_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned          DEF_EFF    = (DEFAULT_HALF < 1) ? 1 : DEFAULT_HALF;
  localparam logic [DIV_WIDTH-1:0] RESET_HALF = DIV_WIDTH'(DEF_EFF);

  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] active_half_q, active_half_d;
  logic [DIV_WIDTH-1:0] pending_half_q, pending_half_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 clk_out_q, clk_out_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 toggle;

  assign toggle = enable && (phase_q == active_half_q - DIV_WIDTH'(1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d         = phase_q;
    active_half_d   = active_half_q;
    pending_half_d  = pending_half_q;
    pending_valid_d = pending_valid_q;
    clk_out_d       = clk_out_q;
    rise_d          = 1'b0;
    fall_d          = 1'b0;
    cnt_d           = cnt_q;

    if (toggle) begin
      phase_d   = '0;
      clk_out_d = ~clk_out_q;
      rise_d    = ~clk_out_q;
      fall_d    = clk_out_q;
      if (!clk_out_q) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (pending_valid_q) begin
        active_half_d   = pending_half_q;
        pending_valid_d = 1'b0;
      end
    end else if (enable) begin
      phase_d = phase_q + DIV_WIDTH'(1);
    end

    // A load in the toggle cycle lands after the boundary swap, so it waits for the next one.
    if (load) begin
      pending_half_d  = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
      pending_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q         <= '0;
      active_half_q   <= RESET_HALF;
      pending_half_q  <= RESET_HALF;
      pending_valid_q <= 1'b0;
      clk_out_q       <= 1'b0;
      rise_q          <= 1'b0;
      fall_q          <= 1'b0;
      cnt_q           <= '0;
    end else begin
      phase_q         <= phase_d;
      active_half_q   <= active_half_d;
      pending_half_q  <= pending_half_d;
      pending_valid_q <= pending_valid_d;
      clk_out_q       <= clk_out_d;
      rise_q          <= rise_d;
      fall_q          <= fall_d;
      cnt_q           <= cnt_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_clock_oscillator.sv
// Directed bench for clock_oscillator: reset, divide ratios, load timing, enable freeze,
// async reset and counter wrap (second instance with a 4-bit counter).
module tb_clock_oscillator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] half_period;
  logic        load;

  logic        clk_out, rise_pulse, fall_pulse;
  logic [31:0] cycle_count;
  logic        w_clk_out, w_rise, w_fall;
  logic [3:0]  w_count;

  int n_checks = 0;
  int n_pass   = 0;

  clock_oscillator #(.DIV_WIDTH(16), .DEFAULT_HALF(1), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .half_period(half_period), .load(load),
    .clk_out(clk_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .cycle_count(cycle_count)
  );

  clock_oscillator #(.DIV_WIDTH(16), .DEFAULT_HALF(1), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(enable), .half_period(half_period), .load(load),
    .clk_out(w_clk_out), .rise_pulse(w_rise), .fall_pulse(w_fall),
    .cycle_count(w_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance n reference edges, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("strobe_exclusive", {31'd0, rise_pulse & fall_pulse}, 32'd0);
    end
  endtask

  task automatic expect_out(input string tag, input logic c, input logic r, input logic f,
                            input logic [31:0] cnt);
    check({tag, "_clk"},  {31'd0, clk_out},    {31'd0, c});
    check({tag, "_rise"}, {31'd0, rise_pulse}, {31'd0, r});
    check({tag, "_fall"}, {31'd0, fall_pulse}, {31'd0, f});
    check({tag, "_cnt"},  cycle_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; half_period = '0;
    step(2);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step(2);
    expect_out("disabled_idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // Default half of 1: toggle every reference cycle.
    enable = 1'b1;
    step(1); expect_out("h1_a", 1'b1, 1'b1, 1'b0, 32'd1);
    step(1); expect_out("h1_b", 1'b0, 1'b0, 1'b1, 32'd1);
    step(1); expect_out("h1_c", 1'b1, 1'b1, 1'b0, 32'd2);
    step(1); expect_out("h1_d", 1'b0, 1'b0, 1'b1, 32'd2);

    // Load 4 coincident with a toggle: one more phase at length 1, then 4/4.
    load = 1'b1; half_period = 16'd4;
    step(1); load = 1'b0;
    expect_out("h4_old_rise", 1'b1, 1'b1, 1'b0, 32'd3);
    step(1); expect_out("h4_fall", 1'b0, 1'b0, 1'b1, 32'd3);
    step(1); expect_out("h4_low1", 1'b0, 1'b0, 1'b0, 32'd3);
    step(2); expect_out("h4_low3", 1'b0, 1'b0, 1'b0, 32'd3);
    step(1); expect_out("h4_rise", 1'b1, 1'b1, 1'b0, 32'd4);
    step(1); expect_out("h4_high2", 1'b1, 1'b0, 1'b0, 32'd4);
    step(2); expect_out("h4_high4", 1'b1, 1'b0, 1'b0, 32'd4);
    step(1); expect_out("h4_fall2", 1'b0, 1'b0, 1'b1, 32'd4);

    // Mid-phase load of 0 (means 1) does not shorten the current low phase.
    load = 1'b1; half_period = 16'd0;
    step(1); load = 1'b0;
    expect_out("z_mid1", 1'b0, 1'b0, 1'b0, 32'd4);
    step(2); expect_out("z_mid3", 1'b0, 1'b0, 1'b0, 32'd4);
    step(1); expect_out("z_rise", 1'b1, 1'b1, 1'b0, 32'd5);
    step(1); expect_out("z_fall", 1'b0, 1'b0, 1'b1, 32'd5);
    step(1); expect_out("z_rise2", 1'b1, 1'b1, 1'b0, 32'd6);

    // Half of 3 with enable dropped for 5 cycles right after the rising edge.
    load = 1'b1; half_period = 16'd3;
    step(1); load = 1'b0;
    expect_out("h3_fall", 1'b0, 1'b0, 1'b1, 32'd6);
    step(1); expect_out("h3_rise", 1'b1, 1'b1, 1'b0, 32'd7);
    enable = 1'b0;
    step(1); expect_out("frz_1", 1'b1, 1'b0, 1'b0, 32'd7);
    step(4); expect_out("frz_5", 1'b1, 1'b0, 1'b0, 32'd7);
    enable = 1'b1;
    step(1); expect_out("res_1", 1'b1, 1'b0, 1'b0, 32'd7);
    step(1); expect_out("res_2", 1'b1, 1'b0, 1'b0, 32'd7);
    step(1); expect_out("res_fall", 1'b0, 1'b0, 1'b1, 32'd7);

    // Reach a high phase, leave a pending load of 5, then reset asynchronously.
    step(3); expect_out("pre_rst_rise", 1'b1, 1'b1, 1'b0, 32'd8);
    load = 1'b1; half_period = 16'd5;
    step(1); load = 1'b0;
    expect_out("pre_rst_high", 1'b1, 1'b0, 1'b0, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1); expect_out("post_rst_a", 1'b1, 1'b1, 1'b0, 32'd1);
    step(1); expect_out("post_rst_b", 1'b0, 1'b0, 1'b1, 32'd1);
    step(1); expect_out("post_rst_c", 1'b1, 1'b1, 1'b0, 32'd2);
    step(1); expect_out("post_rst_d", 1'b0, 1'b0, 1'b1, 32'd2);

    // 17 rising edges: the 4-bit counter wraps to 1, the 32-bit one reads 17.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(33);
    check("wrap_w_count", {28'd0, w_count}, 32'd1);
    check("wrap_w_clk", {31'd0, w_clk_out}, 32'd1);
    check("wrap_main_count", cycle_count, 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
